// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready handshake,
// optional skid buffer, synchronous flush and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 9,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter int                SKID        = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              clr_cnt,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       bubble_cnt
);
    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [15:0]       bubble_cnt_q, bubble_cnt_d;
    logic              in_xfer, out_xfer;

    assign in_ready   = (SKID != 0) ? ~skid_valid_q : (out_ready | ~out_valid_q);
    assign out_valid  = out_valid_q;
    assign out_ctrl   = out_ctrl_q;
    assign out_data   = out_data_q;
    assign bubble_cnt = bubble_cnt_q;
    assign in_xfer    = in_valid & in_ready;
    assign out_xfer   = out_valid_q & out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_ctrl_d   = out_ctrl_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (SKID != 0) begin
            if (!out_valid_q || out_xfer) begin
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_ctrl_d   = skid_ctrl_q;
                    out_data_d   = skid_data_q;
                    skid_valid_d = 1'b0;
                end else if (in_xfer) begin
                    out_valid_d = 1'b1;
                    out_ctrl_d  = in_ctrl;
                    out_data_d  = in_data;
                end else begin
                    out_valid_d = 1'b0;
                    out_ctrl_d  = CTRL_BUBBLE;
                end
            end else if (in_xfer) begin
                skid_valid_d = 1'b1;
                skid_ctrl_d  = in_ctrl;
                skid_data_d  = in_data;
            end
        end else begin
            if (in_xfer) begin
                out_valid_d = 1'b1;
                out_ctrl_d  = in_ctrl;
                out_data_d  = in_data;
            end else if (out_xfer) begin
                out_valid_d = 1'b0;
                out_ctrl_d  = CTRL_BUBBLE;
            end
        end
        // flush kills every held beat but leaves the data registers as they were
        if (flush) begin
            out_valid_d  = 1'b0;
            out_ctrl_d   = CTRL_BUBBLE;
            out_data_d   = out_data_q;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = skid_ctrl_q;
            skid_data_d  = skid_data_q;
        end
        bubble_cnt_d = clr_cnt ? 16'd0 :
                       (!out_valid_q && bubble_cnt_q != 16'hFFFF) ? bubble_cnt_q + 16'd1 :
                       bubble_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_ctrl_q   <= CTRL_BUBBLE;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_ctrl_q   <= out_ctrl_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: drives a SKID=1 and a SKID=0 stage with the same stimulus;
// per-instance scoreboards check beat order, directed checks cover handshake and counter.
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0, clr_cnt = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [8:0]  in_ctrl = '0;
    logic [31:0] in_data = '0;
    logic        rdy1, ov1, rdy0, ov0;
    logic [8:0]  oc1, oc0;
    logic [31:0] od1, od0;
    logic [15:0] bc1, bc0;
    int          errors = 0, checks = 0;
    logic [40:0] q1[$], q0[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(1)) u1 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_ready(rdy1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
        .bubble_cnt(bc1));

    pipe_stage_reg #(.SKID(0)) u0 (
        .clk(clk), .reset_n(reset_n), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_ready(rdy0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
        .bubble_cnt(bc0));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on every output transfer; enqueue accepted beats unless flushed.
    always @(negedge clk) begin
        if (!reset_n) begin
            q1.delete();
            q0.delete();
        end else begin
            if (ov1 && out_ready) begin
                if (q1.size() == 0) chk("sb1_unexpected_beat", {23'd0, oc1, od1}, 64'hDEAD);
                else chk("sb1_beat", {23'd0, oc1, od1}, {23'd0, q1.pop_front()});
            end
            if (ov0 && out_ready) begin
                if (q0.size() == 0) chk("sb0_unexpected_beat", {23'd0, oc0, od0}, 64'hDEAD);
                else chk("sb0_beat", {23'd0, oc0, od0}, {23'd0, q0.pop_front()});
            end
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (in_valid && rdy1) q1.push_back({in_ctrl, in_data});
                if (in_valid && rdy0) q0.push_back({in_ctrl, in_data});
            end
        end
    end

    initial begin
        #3;
        chk("rst_valid", {ov1, ov0}, 2'b00);
        chk("rst_ctrl", {oc1, oc0}, 18'd0);
        chk("rst_data", {od1, od0}, 64'd0);
        chk("rst_cnt", {bc1, bc0}, 32'd0);
        chk("rst_in_ready", {rdy1, rdy0}, 2'b11);
        #9 reset_n = 1'b1;
        // idle: bubble counter and bubble control
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_ctrl", {oc1, oc0}, 18'd0);
        end
        chk("idle_cnt20", {bc1, bc0}, {16'd20, 16'd20});
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_cnt", {bc1, bc0}, 32'd0);
        repeat (65535) tick();
        chk("cnt_max", {bc1, bc0}, 32'hFFFF_FFFF);
        repeat (5) tick();
        chk("cnt_sat", {bc1, bc0}, 32'hFFFF_FFFF);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_at_sat", {bc1, bc0}, 32'd0);
        // streaming at full throughput
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 9'h1A5;
        for (int n = 0; n < 8; n++) begin
            in_data = 32'h10 + 32'(4 * n);
            tick();
            chk("stream_valid", {ov1, ov0}, 2'b11);
            chk("stream_data1", {32'd0, od1}, 64'h10 + 64'(4 * n));
            chk("stream_data0", {32'd0, od0}, 64'h10 + 64'(4 * n));
            chk("stream_ctrl", {oc1, oc0}, {9'h1A5, 9'h1A5});
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid", {ov1, ov0}, 2'b00);
        chk("drain_ctrl", {oc1, oc0}, 18'd0);
        // backpressure: A then B with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 9'h0AA;
        in_data   = 32'hA0;
        tick();
        chk("bp_a_out", {ov1, od1, ov0, od0}, {1'b1, 32'hA0, 1'b1, 32'hA0});
        chk("bp_rdy_a", {rdy1, rdy0}, 2'b10);
        in_ctrl = 9'h0BB;
        in_data = 32'hB0;
        tick();
        chk("bp_hold", {oc1, od1, oc0, od0}, {9'h0AA, 32'hA0, 9'h0AA, 32'hA0});
        chk("bp_rdy_full", {rdy1, rdy0}, 2'b00);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy_comb", {rdy1, rdy0}, 2'b01);
        tick();
        in_valid = 1'b0;
        chk("bp_b_out", {oc1, od1, oc0, od0}, {9'h0BB, 32'hB0, 9'h0BB, 32'hB0});
        chk("bp_rdy_back", {rdy1, rdy0}, 2'b11);
        tick();
        chk("bp_drained", {ov1, ov0}, 2'b00);
        // flush with stage and skid full and a third beat offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 9'h0CC;
        in_data   = 32'hC0;
        tick();
        in_ctrl = 9'h0DD;
        in_data = 32'hD0;
        tick();
        chk("fl_pre_rdy", {rdy1, rdy0}, 2'b00);
        in_ctrl = 9'h0EE;
        in_data = 32'hE0;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {ov1, ov0}, 2'b00);
        chk("fl_ctrl", {oc1, oc0}, 18'd0);
        chk("fl_rdy", {rdy1, rdy0}, 2'b11);
        chk("fl_data_kept", {od1, od0}, {32'hC0, 32'hC0});
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("fl_no_emerge", {ov1, ov0}, 2'b00);
        end
        // beat accepted in a flush cycle is discarded
        in_valid = 1'b1;
        in_ctrl  = 9'h0FF;
        in_data  = 32'hF0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_in_discard", {ov1, ov0}, 2'b00);
        tick();
        chk("fl_in_gone", {ov1, ov0}, 2'b00);
        // asynchronous reset with skid full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 9'h011;
        in_data   = 32'h1000;
        tick();
        in_ctrl = 9'h022;
        in_data = 32'h2000;
        tick();
        chk("ar_pre_rdy", {rdy1, ov1}, 2'b01);
        #2 reset_n = 1'b0;
        #1;
        in_valid = 1'b0;
        chk("ar_valid", {ov1, ov0}, 2'b00);
        chk("ar_ctrl", {oc1, oc0}, 18'd0);
        chk("ar_data", {od1, od0}, 64'd0);
        chk("ar_cnt", {bc1, bc0}, 32'd0);
        chk("ar_rdy", {rdy1, rdy0}, 2'b11);
        tick();
        reset_n   = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 9'h155;
        in_data   = 32'h123;
        tick();
        in_valid = 1'b0;
        chk("ar_first", {ov1, oc1, od1, ov0, oc0, od0}, {1'b1, 9'h155, 32'h123, 1'b1, 9'h155, 32'h123});
        tick();
        chk("ar_drained", {ov1, ov0}, 2'b00);
        tick();
        chk("sb1_empty", 64'(q1.size()), 64'd0);
        chk("sb0_empty", 64'(q0.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline stage register for the MIPS pipeline. It replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB register modules. It carries a control bundle and a data bundle with a valid/ready handshake, an optional skid buffer for full throughput under backpressure, and a synchronous flush. Control fields are forced to a safe bubble value whenever the stage holds no valid beat. A saturating bubble counter supports performance debug.

Parameters:
DATA_W, 32, width of data bundle (PC, operands, immediate, addresses, concatenated)
CTRL_W, 9, width of control bundle (RegWrite, MemWrite, Branch, ...)
CTRL_BUBBLE, 0, value driven on out_ctrl when out_valid=0; CTRL_W bits
SKID, 1, 1 = two-entry skid buffer (full throughput, registered in_ready); 0 = single register (combinational in_ready)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous flush; kills all held beats
clr_cnt  input  1  synchronous clear of bubble_cnt
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat this cycle
in_ctrl  input  CTRL_W  upstream control bundle
in_data  input  DATA_W  upstream data bundle
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
out_ctrl  output  CTRL_W  registered control bundle
out_data  output  DATA_W  registered data bundle
bubble_cnt  output  16  saturating count of cycles with out_valid=0

Behaviour:
- Reset (reset_n=0, asynchronous) drives these values:
  - out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0, bubble_cnt=0.
  - Skid entry empty, skid contents 0.
  - in_ready=1 for both SKID settings.
- Handshake:
  - An input transfer occurs when in_valid&in_ready.
  - An output transfer occurs when out_valid&out_ready.
  - in_data and in_ctrl are sampled only on an input transfer.
  - out_data and out_ctrl hold stable while out_valid=1 and out_ready=0.
- Latency: an accepted beat appears on the outputs the next cycle if the output register is free or draining. Beats leave in strict acceptance order.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - On an input transfer, the output register loads the beat.
  - On an output transfer with no input transfer: out_valid goes to 0 and out_ctrl to CTRL_BUBBLE.
- SKID=1:
  - in_ready = ~skid_valid (registered; no combinational path from out_ready).
  - The output register loads when it is empty or when an output transfer occurs. Source is the skid entry if it is valid, else in_* on an input transfer.
  - When the output register is full, out_ready=0 and an input transfer occurs, the beat goes to the skid entry. in_ready falls the next cycle.
  - Skid valid and an output transfer: the skid beat moves to the output and the skid entry empties. A simultaneous input transfer cannot occur because in_ready=0.
- Bubble rule: whenever out_valid is 0, out_ctrl = CTRL_BUBBLE. out_data retains its last value and is don't-care to consumers.
- Flush (synchronous, highest priority over all handshakes):
  - Next cycle: out_valid=0, skid empty, out_ctrl=CTRL_BUBBLE.
  - Data registers are unchanged.
  - A beat accepted in the flush cycle is discarded.
  - in_ready=1 the cycle after flush.
  - An output transfer in the flush cycle completes normally, since downstream saw it.
- bubble_cnt:
  - Increments by 1 on each rising edge where out_valid=0, saturating at 16'hFFFF.
  - clr_cnt=1 sets it to 0 and takes priority over the increment.
  - flush does not affect it.
- No beat is ever duplicated or lost except by flush.

Test Plan:
- Reset, then in_valid=1 every cycle, in_ctrl=9'h1A5, in_data=32'h0000_0010+4n, out_ready=1 -> out_valid=1 from cycle 1; out_data steps by 4 per cycle; throughput 1/cycle for both SKID values.
- SKID=1: fill the stage with beats A, B while out_ready=0 -> out shows A; B is in skid; in_ready=0 the next cycle. Raise out_ready -> B follows A the next cycle and in_ready returns to 1; no loss and no duplication.
- SKID=0 under the same stimulus -> in_ready tracks out_ready combinationally; beat B is refused until A drains.
- Assert flush with stage and skid full and in_valid=1 -> next cycle out_valid=0, out_ctrl=CTRL_BUBBLE (0), in_ready=1; none of the three beats ever emerges.
- Idle 20 cycles after reset with in_valid=0 -> bubble_cnt=20 and out_ctrl=0 throughout. Pulse clr_cnt -> 0. Force 70000 idle cycles -> bubble_cnt holds at 65535.
- Drop reset_n mid-transfer while skid is full -> outputs reach reset values immediately without waiting for clk; after release the first accepted beat emerges with correct data.
